// File: rtl/package_settings.sv
// Shared sizes and types for the filter/peak-detection slice.
package package_settings;

    localparam int SIZE_ADC_DATA    = 13;
    localparam int SIZE_FILTER_DATA = 15;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PEAK,
        SEARCH,
        HOLDOFF
    } peak_state_t;

    // "time" is reserved in SystemVerilog, so the timestamp field is ts
    typedef struct packed {
        logic signed [SIZE_FILTER_DATA:0] amp;
        logic [31:0]                      ts;
        logic                             pileup;
    } evt_t;

endpackage

// File: rtl/event_fifo.sv
// First-word-fall-through event FIFO with a saturating drop counter.
module event_fifo
    import package_settings::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  evt_t        push_evt,
    input  logic        pop_ready,
    output logic        valid,
    output evt_t        head,
    output logic [15:0] drop_cnt
);

    // DEPTH must be a power of 2 (>= 2); the extra pointer bit marks wrap
    localparam int unsigned AW = $clog2(DEPTH);

    evt_t          mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          full;
    logic          empty;
    logic          pop;
    logic          accept;
    logic          drop;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign valid  = ~empty;
    assign pop    = valid & pop_ready;
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;
    assign head   = valid ? mem[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr[AW-1:0]] <= push_evt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            drop_cnt <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/filter_peak_ctrl.sv
// Rising-edge trigger, delayed peak search over the filter output, and
// queuing of {amp, timestamp, pile-up} events.
module filter_peak_ctrl
    import package_settings::*;
#(
    parameter int unsigned PEAK_WAIT   = 16,
    parameter int unsigned SEARCH_LEN  = 8,
    parameter int unsigned HOLDOFF_LEN = 32,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [SIZE_ADC_DATA:0]         threshold,
    input  logic [SIZE_ADC_DATA:0]         adc_data,
    input  logic signed [SIZE_FILTER_DATA:0] filter_data,
    output logic                           evt_valid,
    input  logic                           evt_ready,
    output logic signed [SIZE_FILTER_DATA:0] evt_amp,
    output logic [31:0]                    evt_time,
    output logic                           evt_pileup,
    output logic                           busy,
    output logic [15:0]                    drop_cnt
);

    localparam int unsigned MAX_LEN =
        (PEAK_WAIT > SEARCH_LEN) ?
            ((PEAK_WAIT > HOLDOFF_LEN) ? PEAK_WAIT : HOLDOFF_LEN) :
            ((SEARCH_LEN > HOLDOFF_LEN) ? SEARCH_LEN : HOLDOFF_LEN);
    localparam int unsigned CW = $clog2(MAX_LEN + 1);

    peak_state_t                     state;
    peak_state_t                     state_next;
    logic [CW-1:0]                   cnt;
    logic [CW-1:0]                   cnt_next;
    logic [SIZE_ADC_DATA:0]          adc_prev;
    logic signed [SIZE_ADC_DATA+1:0] diff;
    logic                            trig;
    logic [31:0]                     ts;
    logic [31:0]                     evt_ts;
    logic [31:0]                     evt_ts_next;
    logic signed [SIZE_FILTER_DATA:0] max_amp;
    logic signed [SIZE_FILTER_DATA:0] max_next;
    logic                            pileup;
    logic                            pileup_next;
    logic                            push;
    evt_t                            push_evt;
    evt_t                            head;

    assign diff = $signed({1'b0, adc_data}) - $signed({1'b0, adc_prev});
    assign trig = diff > $signed({1'b0, threshold});
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            adc_prev <= '0;
            ts       <= '0;
            state    <= IDLE;
            cnt      <= '0;
            evt_ts   <= '0;
            max_amp  <= '0;
            pileup   <= 1'b0;
        end else begin
            adc_prev <= adc_data;
            ts       <= ts + 32'd1;
            state    <= state_next;
            cnt      <= cnt_next;
            evt_ts   <= evt_ts_next;
            max_amp  <= max_next;
            pileup   <= pileup_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt + CW'(1);
        evt_ts_next = evt_ts;
        max_next    = max_amp;
        pileup_next = pileup;
        push        = 1'b0;

        if (!enable) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_next = '0;
                    if (trig) begin
                        state_next  = WAIT_PEAK;
                        evt_ts_next = ts;
                        pileup_next = 1'b0;
                    end
                end
                WAIT_PEAK: begin
                    pileup_next = pileup | trig;
                    if (cnt == CW'(PEAK_WAIT - 1)) begin
                        state_next = SEARCH;
                        cnt_next   = '0;
                    end
                end
                SEARCH: begin
                    pileup_next = pileup | trig;
                    // strict > keeps the earlier sample on ties
                    if ((cnt == '0) || (filter_data > max_amp)) begin
                        max_next = filter_data;
                    end
                    if (cnt == CW'(SEARCH_LEN - 1)) begin
                        push       = 1'b1;
                        state_next = HOLDOFF;
                        cnt_next   = '0;
                    end
                end
                HOLDOFF: begin
                    if (cnt == CW'(HOLDOFF_LEN - 1)) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // The pushed event includes the final search sample and a trig seen on it
    assign push_evt = '{amp: max_next, ts: evt_ts, pileup: pileup_next};

    event_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_event_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_evt (push_evt),
        .pop_ready(evt_ready),
        .valid    (evt_valid),
        .head     (head),
        .drop_cnt (drop_cnt)
    );

    assign evt_amp    = head.amp;
    assign evt_time   = head.ts;
    assign evt_pileup = head.pileup;

endmodule

// File: doc/filter_peak_ctrl.md
FILTER_PEAK_CTRL -- requirements
Module: filter_peak_ctrl

Interface
REQ-001 The block SHALL have parameter PEAK_WAIT, default 16, setting the cycles from trigger to the start of the peak search (covers filter latency).
REQ-002 The block SHALL have parameter SEARCH_LEN, default 8, setting the number of filter samples examined per event.
REQ-003 The block SHALL have parameter HOLDOFF_LEN, default 32, setting the dead time after each search, in cycles.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4, setting the event FIFO depth; it SHALL be a power of 2.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 enable  input  1  arms the trigger; low forces the FSM to IDLE.
REQ-008 threshold  input  SIZE_ADC_DATA+1  unsigned rising-edge trigger threshold.
REQ-009 adc_data  input  SIZE_ADC_DATA+1  raw ADC sample, the same sample stream that feeds v3_filter.
REQ-010 filter_data  input  SIZE_FILTER_DATA+1  signed cusp-like filter output.
REQ-011 evt_valid  output  1  FIFO head holds an event.
REQ-012 evt_ready  input  1  consumer accepts the head event.
REQ-013 evt_amp  output  SIZE_FILTER_DATA+1  signed peak amplitude of the head event.
REQ-014 evt_time  output  32  timestamp of the head event.
REQ-015 evt_pileup  output  1  pile-up flag of the head event.
REQ-016 busy  output  1  high whenever the FSM is not in IDLE.
REQ-017 drop_cnt  output  16  saturating count of events lost because the FIFO was full.

Function
REQ-018 The block SHALL hold adc_prev, the previous adc_data sample, and form diff = adc_data - adc_prev at SIZE_ADC_DATA+2 bits, signed.
REQ-019 trig SHALL be true when diff > threshold, compared signed with threshold zero-extended.
REQ-020 The block SHALL run a free-running 32-bit timestamp counter, incrementing every cycle and wrapping from 0xFFFFFFFF to 0.
REQ-021 The FSM SHALL have the states IDLE, WAIT_PEAK, SEARCH and HOLDOFF.
REQ-022 IDLE: when enable and trig are both high at an edge, the FSM SHALL go to WAIT_PEAK, latch the current timestamp and clear the pile-up flag.
REQ-023 WAIT_PEAK: the FSM SHALL stay exactly PEAK_WAIT cycles, then go to SEARCH.
REQ-024 SEARCH: over exactly SEARCH_LEN cycles, the block SHALL track the maximum signed filter_data, with ties keeping the earlier value; the first search sample SHALL initialise the maximum.
REQ-025 On leaving SEARCH, the block SHALL push {amp, time, pileup} into the FIFO and the FSM SHALL go to HOLDOFF.
REQ-026 HOLDOFF: the FSM SHALL stay exactly HOLDOFF_LEN cycles and ignore trig, then go to IDLE.
REQ-027 A trig in WAIT_PEAK or SEARCH SHALL set the pile-up flag without restarting timing.
REQ-028 enable low in any state SHALL send the FSM to IDLE on the next edge and discard the in-progress event; FIFO contents SHALL be kept.
REQ-029 The FIFO SHALL be first-word-fall-through: evt_* SHALL be valid in the cycle after the push into an empty FIFO.
REQ-030 A pop SHALL occur on an edge where evt_valid and evt_ready are both high.
REQ-031 Push when full: the event SHALL be accepted if a pop occurs on the same edge; otherwise it SHALL be dropped and drop_cnt SHALL increment, saturating at 0xFFFF.
REQ-032 Simultaneous push and pop on an empty FIFO is not possible, because evt_valid is low.
REQ-033 Pointers SHALL be log2(FIFO_DEPTH)+1 bits; full and empty SHALL be derived from pointer wrap.

Reset
REQ-034 On reset low, the block SHALL immediately clear the FSM to IDLE, adc_prev, the timestamp, the counters, the FIFO pointers and drop_cnt.
REQ-035 During reset, evt_valid, busy and evt_pileup SHALL be 0 and evt_amp and evt_time SHALL be 0.
REQ-036 Reset asserted mid-event SHALL discard the event and empty the FIFO.

Structure
REQ-037 SIZE_ADC_DATA and SIZE_FILTER_DATA SHALL come from package_settings.
REQ-038 The state enum and the event struct {amp, time, pileup} SHALL be added to package_settings.
REQ-039 The FIFO SHALL be a sub-module, event_fifo, parameterised by depth and carrying the event struct.

Verification
REQ-040 With threshold=100, a step of adc 0->500 at timestamp 10 and a filter pulse peaking at 1234 on the 5th search sample, the bench SHALL see one event amp=1234, time=10, pileup=0, with busy low 1+PEAK_WAIT+SEARCH_LEN+HOLDOFF_LEN cycles after the trigger.
REQ-041 With a second step 6 cycles after the first, the bench SHALL see a single event with pileup=1.
REQ-042 With a second step during HOLDOFF, the bench SHALL see no new event and no pile-up flag.
REQ-043 With evt_ready=0 and 6 triggers, the bench SHALL see the FIFO hold 4 events and drop_cnt=2; then with evt_ready=1, 4 pops in order.
REQ-044 With enable dropped in SEARCH, the bench SHALL see busy fall next cycle, no push, and existing FIFO entries intact.
REQ-045 With reset pulsed mid-SEARCH with 2 events queued, the bench SHALL see evt_valid=0, drop_cnt=0 and the timestamp restart at 0.
